sample_queue: RTL and testbench
===============================

SAMPLE_QUEUE -- requirements
Module: sample_queue

Interface
REQ-001 Parameter: DEPTH, 1024, number of circular-buffer slots (power of two, >= 4); window length FILL = DEPTH-1.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 valid  input  1  sample-pair-ready level from codec interface; may stay high for many cycles.
REQ-005 lft_in  input  16  signed left sample, stable while valid high.
REQ-006 rht_in  input  16  signed right sample, stable while valid high.
REQ-007 lft_smpl  output  16  left sample being sequenced out.
REQ-008 rht_smpl  output  16  right sample being sequenced out.
REQ-009 sequencing  output  1  high exactly on cycles where lft_smpl/rht_smpl carry window data.
REQ-010 full  output  1  high once FILL samples are held.

Function
REQ-011 Write strobe wrt = valid & ~valid_q (rising edge); one write per valid assertion regardless of its duration.
REQ-012 On wrt at cycle T, {lft_in,rht_in} SHALL be written at new_ptr; new_ptr increments modulo DEPTH.
REQ-013 Occupancy cnt (0..FILL) increments on wrt while cnt < FILL and saturates at FILL; full = (cnt == FILL).
REQ-014 When wrt occurs with cnt == FILL before the write, old_ptr increments modulo DEPTH in the same cycle.
REQ-015 A burst SHALL start for every wrt after which cnt == FILL (including the write making cnt reach FILL).
REQ-016 Burst: read addresses old_ptr, old_ptr+1, ... (mod DEPTH), FILL of them, issued cycles T+1..T+FILL.
REQ-017 RAM read latency is one cycle; data valid and sequencing high cycles T+2..T+FILL+1 inclusive, oldest sample first, newest (just written) last.
REQ-018 State machine: IDLE -> SEQ on burst start; SEQ -> IDLE after FILL reads unless pending set; SEQ -> SEQ (fresh burst, no gap cycle) if pending set.
REQ-019 wrt during SEQ: write and pointer updates proceed per REQ-012..014; pending SHALL be set; current burst addresses SHALL be unaffected (new slot lies outside window).
REQ-020 Read-address wrap from DEPTH-1 to 0 SHALL be seamless within a burst.
REQ-021 lft_smpl/rht_smpl SHALL hold last value when sequencing low.
REQ-022 No arithmetic on sample data; widths preserved, 16 bits each.

Reset
REQ-023 rst_n low SHALL immediately clear: new_ptr, old_ptr, cnt, pending, valid_q, state=IDLE, sequencing=0, full=0, lft_smpl=0, rht_smpl=0.
REQ-024 RAM contents need not reset; reset mid-burst SHALL abort the burst, and no burst occurs until FILL new writes.

Structure
REQ-025 Shared package eq_pkg SHALL hold the state typedef (IDLE, SEQ) and constant SMPL_W = 16.
REQ-026 Sub-module dp_ram: one synchronous write port, one synchronous read port (1-cycle latency), width 2*SMPL_W, depth DEPTH; sample_queue holds all pointers and control.

Verification (DEPTH=8, FILL=7, valid pulses 3 cycles wide, lft_in=k, rht_in=-k for sample k)
REQ-027 Reset asserted -> all outputs 0; samples 1..6 written -> sequencing never high, full=0.
REQ-028 Sample 7 at cycle T -> full=1; sequencing high T+2..T+8; lft_smpl 1..7, rht_smpl -1..-7.
REQ-029 Samples 8, 9 -> bursts 2..8 then 3..9, read address wraps 7->0 mid-burst without gap.
REQ-030 valid held high 50 cycles with sample 10 -> exactly one write; burst 4..10.
REQ-031 Sample 11 edge arrives 3 cycles into burst -> burst 4..10 completes unchanged, next burst 5..11 follows with no idle cycle.
REQ-032 rst_n pulsed low mid-burst -> sequencing 0 immediately; next 6 samples produce no burst; 7th produces burst of those 7.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and constants for the sample queue and its storage.
package eq_pkg;
  localparam int SMPL_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_t;
endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module dp_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sample_queue.sv
// Circular sample window: each new stereo sample (once the window is full)
// triggers a burst that replays the whole window, oldest sample first.
module sample_queue
  import eq_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [SMPL_W-1:0] lft_in,
  input  logic [SMPL_W-1:0] rht_in,
  output logic [SMPL_W-1:0] lft_smpl,
  output logic [SMPL_W-1:0] rht_smpl,
  output logic              sequencing,
  output logic              full
);
  localparam int AW   = $clog2(DEPTH);
  localparam int FILL = DEPTH - 1;

  logic                valid_q;
  logic [AW-1:0]       new_ptr;
  logic [AW-1:0]       old_ptr;
  logic [AW-1:0]       cnt;
  logic                pending;
  state_t              state;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       rd_idx;
  logic [2*SMPL_W-1:0] rd_q;
  logic [2*SMPL_W-1:0] hold;

  logic          wrt;
  logic          at_fill;
  logic          burst_start;
  logic          rd_en;
  logic          last_rd;
  logic [AW-1:0] old_ptr_next;

  assign wrt          = valid & ~valid_q;
  assign at_fill      = (cnt == AW'(FILL));
  assign burst_start  = wrt && (cnt >= AW'(FILL - 1));
  assign old_ptr_next = (wrt && at_fill) ? old_ptr + AW'(1) : old_ptr;
  assign rd_en        = (state == SEQ);
  assign last_rd      = rd_en && (rd_idx == AW'(FILL - 1));

  dp_ram #(
    .DEPTH(DEPTH),
    .WIDTH(2 * SMPL_W)
  ) u_ram (
    .clk    (clk),
    .we     (wrt),
    .wr_addr(new_ptr),
    .wr_data({lft_in, rht_in}),
    .re     (rd_en),
    .rd_addr(rd_ptr),
    .rd_data(rd_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      new_ptr    <= '0;
      old_ptr    <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      state      <= IDLE;
      rd_ptr     <= '0;
      rd_idx     <= '0;
      sequencing <= 1'b0;
      hold       <= '0;
    end else begin
      valid_q    <= valid;
      sequencing <= rd_en;
      if (sequencing) hold <= rd_q;

      if (wrt) begin
        new_ptr <= new_ptr + AW'(1);
        old_ptr <= old_ptr_next;
        if (!at_fill) cnt <= cnt + AW'(1);
      end

      case (state)
        IDLE: begin
          if (burst_start) begin
            state  <= SEQ;
            rd_ptr <= old_ptr_next;
            rd_idx <= '0;
          end
        end
        SEQ: begin
          rd_ptr <= rd_ptr + AW'(1);
          rd_idx <= rd_idx + AW'(1);
          if (last_rd) begin
            // A write seen during this burst (or on its final read cycle)
            // chains straight into a fresh burst with no idle cycle.
            pending <= 1'b0;
            if (pending || burst_start) begin
              rd_ptr <= old_ptr_next;
              rd_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (burst_start) begin
            pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lft_smpl = sequencing ? rd_q[2*SMPL_W-1:SMPL_W] : hold[2*SMPL_W-1:SMPL_W];
  assign rht_smpl = sequencing ? rd_q[SMPL_W-1:0]        : hold[SMPL_W-1:0];
  assign full     = at_fill;
endmodule

// File: tb/tb_sample_queue.sv
// Directed bench for sample_queue at DEPTH=8: a per-cycle expectation schedule
// of burst contents, checked on every falling edge.
module tb_sample_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] lft_in = '0;
  logic [15:0] rht_in = '0;
  logic [15:0] lft_smpl;
  logic [15:0] rht_smpl;
  logic        sequencing;
  logic        full;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int full_cyc = 1 << 30;
  int hold = 0;
  bit exp_on [1024];
  int exp_l  [1024];

  sample_queue #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .lft_in    (lft_in),
    .rht_in    (rht_in),
    .lft_smpl  (lft_smpl),
    .rht_smpl  (rht_smpl),
    .sequencing(sequencing),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step();
    logic [15:0] el;
    @(negedge clk);
    cyc++;
    chk("sequencing", 16'(sequencing), 16'(exp_on[cyc]));
    if (exp_on[cyc]) hold = exp_l[cyc];
    el = 16'(hold);
    chk("lft_smpl", lft_smpl, el);
    chk("rht_smpl", rht_smpl, -el);
    chk("full", 16'(full), 16'(cyc >= full_cyc));
  endtask

  task automatic expect_burst(input int start, input int first);
    for (int i = 0; i < 7; i++) begin
      exp_on[start + i] = 1'b1;
      exp_l[start + i]  = first + i;
    end
  endtask

  task automatic pulse(input int k, input int width);
    lft_in = 16'(k);
    rht_in = 16'(-k);
    valid  = 1'b1;
    $display("cyc %0d: sample %0d, valid high %0d cycles", cyc, k, width);
    repeat (width) step();
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_sequencing", 16'(sequencing), 16'h0000);
    chk("reset_full", 16'(full), 16'h0000);
    chk("reset_lft", lft_smpl, 16'h0000);
    chk("reset_rht", rht_smpl, 16'h0000);
    rst_n = 1'b1;

    // Samples 1..6: window not yet full, no bursts.
    for (int k = 1; k <= 6; k++) begin
      pulse(k, 3);
      idle(2);
    end

    // Sample 7 fills the window: full next cycle, burst 1..7 two cycles after the write.
    full_cyc = cyc + 1;
    expect_burst(cyc + 2, 1);
    pulse(7, 3);
    idle(7);

    // Samples 8 and 9; the 9 burst wraps the read address 7 -> 0.
    expect_burst(cyc + 2, 2);
    pulse(8, 3);
    idle(7);
    expect_burst(cyc + 2, 3);
    pulse(9, 3);
    idle(7);

    // Long valid level: one write only, a single burst 4..10.
    expect_burst(cyc + 2, 4);
    pulse(10, 50);
    idle(3);

    // Sample 12 arrives three cycles into the 5..11 burst: 6..12 follows back to back.
    expect_burst(cyc + 2, 5);
    expect_burst(cyc + 9, 6);
    pulse(11, 3);
    idle(2);
    pulse(12, 3);
    idle(12);

    // Reset in the middle of the 7..13 burst aborts it at once.
    expect_burst(cyc + 2, 7);
    pulse(13, 3);
    rst_n = 1'b0;
    for (int i = cyc + 1; i < 1024; i++) exp_on[i] = 1'b0;
    hold = 0;
    full_cyc = 1 << 30;
    #1;
    chk("midburst_reset_sequencing", 16'(sequencing), 16'h0000);
    chk("midburst_reset_full", 16'(full), 16'h0000);
    chk("midburst_reset_lft", lft_smpl, 16'h0000);
    chk("midburst_reset_rht", rht_smpl, 16'h0000);
    step();
    rst_n = 1'b1;
    idle(2);

    // Six fresh samples produce no burst; the seventh replays exactly those seven.
    for (int k = 21; k <= 26; k++) begin
      pulse(k, 3);
      idle(2);
    end
    full_cyc = cyc + 1;
    expect_burst(cyc + 2, 21);
    pulse(27, 3);
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
